// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: opcodes, state encoding,
// instruction classes and datapath select encodings.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_U     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_J     = 7'b1101111;
    localparam logic [6:0] OPC_B     = 7'b1100011;
    localparam logic [6:0] OPC_IJALR = 7'b1100111;
    localparam logic [6:0] OPC_I_L   = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_R     = 7'b0110011;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_R, CLS_I, CLS_LUI, CLS_AUIPC, CLS_LOAD,
        CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILL
    } op_class_e;

    localparam logic [1:0] PC_PLUS4     = 2'd0;
    localparam logic [1:0] PC_OLDPC_IMM = 2'd1;
    localparam logic [1:0] PC_JALR      = 2'd2;

    localparam logic [1:0] SRCA_RS1   = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_ZERO  = 2'd2;

    localparam logic [1:0] SRCB_RS2 = 2'd0;
    localparam logic [1:0] SRCB_IMM = 2'd1;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle FSM (master) and the datapath/memory (slave).
interface multicycle_ctrl_if;
    logic [6:0] iv_Opcode;
    logic       i_Br_taken;
    logic       i_Mem_ready;
    logic       o_Mem_rd;
    logic       o_Mem_wr;
    logic       o_IR_we;
    logic       o_PC_we;
    logic [1:0] ov_PC_sel;
    logic [1:0] ov_ALU_srcA;
    logic [1:0] ov_ALU_srcB;
    logic       o_Reg_we;
    logic [1:0] ov_Wb_sel;
    logic       o_Mem_err;
    logic [2:0] ov_State;

    modport master (
        input  iv_Opcode, i_Br_taken, i_Mem_ready,
        output o_Mem_rd, o_Mem_wr, o_IR_we, o_PC_we, ov_PC_sel, ov_ALU_srcA,
               ov_ALU_srcB, o_Reg_we, ov_Wb_sel, o_Mem_err, ov_State
    );

    modport slave (
        output iv_Opcode, i_Br_taken, i_Mem_ready,
        input  o_Mem_rd, o_Mem_wr, o_IR_we, o_PC_we, ov_PC_sel, ov_ALU_srcA,
               ov_ALU_srcB, o_Reg_we, ov_Wb_sel, o_Mem_err, ov_State
    );
endinterface

// File: rtl/multicycle_ctrl_op_class_dec.sv
// Combinational opcode classifier; anything unlisted maps to CLS_ILL.
module op_class_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_e  class_o
);
    always_comb begin
        class_o = CLS_ILL;
        case (opcode_i)
            OPC_R:     class_o = CLS_R;
            OPC_I:     class_o = CLS_I;
            OPC_U:     class_o = CLS_LUI;
            OPC_AUIPC: class_o = CLS_AUIPC;
            OPC_I_L:   class_o = CLS_LOAD;
            OPC_S:     class_o = CLS_STORE;
            OPC_B:     class_o = CLS_BRANCH;
            OPC_J:     class_o = CLS_JAL;
            OPC_IJALR: class_o = CLS_JALR;
            default:   class_o = CLS_ILL;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM with memory-wait timeout and refetch.
// Optional: define MULTICYCLE_ILLEGAL_TRAP_EN to trap (sticky) on unlisted opcodes.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    multicycle_ctrl_if.master   bus
);
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    op_class_e  cls_q, cls_d, dec_cls;
    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;

    logic       rd_raw, wr_raw, timeout;
    logic       ir_we, pc_we, reg_we;
    logic [1:0] pc_sel, srca, srcb, wb_sel;

    op_class_dec u_dec (
        .opcode_i (bus.iv_Opcode),
        .class_o  (dec_cls)
    );

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        rd_raw  = 1'b0;
        wr_raw  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        reg_we  = 1'b0;
        pc_sel  = PC_PLUS4;
        srca    = SRCA_RS1;
        srcb    = SRCB_RS2;
        wb_sel  = WB_ALU;

        case (state_q)
            FETCH: begin
                // err_q marks the dead cycle after a timeout: strobe drops before refetch
                if (!err_q) begin
                    rd_raw = 1'b1;
                    if (bus.i_Mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = DECODE;
                    end
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                cls_d = dec_cls;
                case (dec_cls)
                    CLS_R:      state_d = WB;
                    CLS_I:      begin srcb = SRCB_IMM; state_d = WB; end
                    CLS_LUI:    begin srca = SRCA_ZERO; srcb = SRCB_IMM; state_d = WB; end
                    CLS_AUIPC:  begin srca = SRCA_OLDPC; srcb = SRCB_IMM; state_d = WB; end
                    CLS_LOAD,
                    CLS_STORE:  begin srcb = SRCB_IMM; state_d = MEM; end
                    CLS_BRANCH: begin
                        pc_we   = bus.i_Br_taken;
                        pc_sel  = PC_OLDPC_IMM;
                        state_d = FETCH;
                    end
                    CLS_JAL:    begin pc_we = 1'b1; pc_sel = PC_OLDPC_IMM; state_d = WB; end
                    CLS_JALR:   begin pc_we = 1'b1; pc_sel = PC_JALR; state_d = WB; end
                    default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                        state_d = TRAP;
`else
                        state_d = FETCH;
`endif
                    end
                endcase
            end
            MEM: begin
                rd_raw = (cls_q == CLS_LOAD);
                wr_raw = (cls_q != CLS_LOAD);
                if (bus.i_Mem_ready)
                    state_d = (cls_q == CLS_LOAD) ? WB : FETCH;
            end
            WB: begin
                reg_we  = 1'b1;
                state_d = FETCH;
                if (cls_q == CLS_LOAD)
                    wb_sel = WB_MEM;
                else if (cls_q == CLS_JAL || cls_q == CLS_JALR)
                    wb_sel = WB_PC4;
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        // Ready in the last wait cycle completes normally, so it masks the timeout
        timeout = (rd_raw | wr_raw) & ~bus.i_Mem_ready & (wait_q == TO_LAST);
        if (timeout)
            state_d = FETCH;
        err_d = timeout;

        if (timeout || (state_d != state_q) || !((rd_raw | wr_raw) & ~bus.i_Mem_ready))
            wait_d = '0;
        else
            wait_d = wait_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FETCH;
            cls_q   <= CLS_R;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_Mem_rd    = rd_raw & ~i_rst;
    assign bus.o_Mem_wr    = wr_raw & ~timeout & ~i_rst;
    assign bus.o_IR_we     = ir_we & ~i_rst;
    assign bus.o_PC_we     = pc_we & ~i_rst;
    assign bus.o_Reg_we    = reg_we & ~i_rst;
    assign bus.ov_PC_sel   = i_rst ? 2'b00 : pc_sel;
    assign bus.ov_ALU_srcA = i_rst ? 2'b00 : srca;
    assign bus.ov_ALU_srcB = i_rst ? 2'b00 : srcb;
    assign bus.ov_Wb_sel   = i_rst ? 2'b00 : wb_sel;
    assign bus.o_Mem_err   = timeout & ~i_rst;
    assign bus.ov_State    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle stimulus and expected state/outputs queued, then replayed.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        br;
        logic [6:0]  opc;
        logic [2:0]  st;
        logic [13:0] outs;
    } vec_t;

    vec_t  q[$];
    int    nvec = 0;
    int    nerr = 0;
    string name;
    logic [6:0] opc_cur;

    localparam logic [13:0] Z = 14'b0;

    // {rd, wr, ir_we, pc_we, pc_sel, srcA, srcB, reg_we, wb_sel, err}
    function automatic logic [13:0] o(input logic rd, input logic wr, input logic ir,
                                      input logic pcwe, input logic [1:0] pcsel,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic rwe, input logic [1:0] wb, input logic err);
        return {rd, wr, ir, pcwe, pcsel, sa, sb, rwe, wb, err};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic rst, input logic rdy, input logic br,
                        input logic [2:0] st, input logic [13:0] outs);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.br = br; v.opc = opc_cur; v.st = st; v.outs = outs;
        q.push_back(v);
    endtask

    // Zero-wait fetch followed by decode
    task automatic pre(input logic [6:0] opc);
        opc_cur = opc;
        push(0, 1, 0, FETCH,  o(1,0,1,1,0,0,0,0,0,0));
        push(0, 1, 0, DECODE, Z);
    endtask

    task automatic run(input string nm);
        vec_t v;
        int   idx;
        logic [13:0] got;
        name = nm;
        idx  = 0;
        while (q.size() > 0) begin
            v = q.pop_front();
            @(negedge i_clk);
            i_rst           = v.rst;
            bus.i_Mem_ready = v.rdy;
            bus.i_Br_taken  = v.br;
            bus.iv_Opcode   = v.opc;
            #1;
            got = {bus.o_Mem_rd, bus.o_Mem_wr, bus.o_IR_we, bus.o_PC_we, bus.ov_PC_sel,
                   bus.ov_ALU_srcA, bus.ov_ALU_srcB, bus.o_Reg_we, bus.ov_Wb_sel, bus.o_Mem_err};
            check($sformatf("%s[%0d].state", name, idx), 16'(bus.ov_State), 16'(v.st));
            check($sformatf("%s[%0d].outs", name, idx), 16'(got), 16'(v.outs));
            idx++;
        end
    endtask

    initial begin
        i_rst = 1'b1;
        bus.iv_Opcode = OPC_R;
        bus.i_Br_taken = 1'b0;
        bus.i_Mem_ready = 1'b0;
        opc_cur = OPC_R;
        repeat (2) @(posedge i_clk);

        push(1, 1, 1, FETCH, Z);
        push(1, 1, 1, FETCH, Z);
        run("reset");

        pre(OPC_I);
        push(0, 1, 0, EXEC, o(0,0,0,0,0,0,1,0,0,0));
        push(0, 1, 0, WB,   o(0,0,0,0,0,0,0,1,0,0));
        run("addi");

        pre(OPC_I_L);
        push(0, 1, 0, EXEC, o(0,0,0,0,0,0,1,0,0,0));
        push(0, 0, 0, MEM,  o(1,0,0,0,0,0,0,0,0,0));
        push(0, 0, 0, MEM,  o(1,0,0,0,0,0,0,0,0,0));
        push(0, 1, 0, MEM,  o(1,0,0,0,0,0,0,0,0,0));
        push(0, 1, 0, WB,   o(0,0,0,0,0,0,0,1,1,0));
        run("load_wait2");

        pre(OPC_B);
        push(0, 1, 0, EXEC, o(0,0,0,0,1,0,0,0,0,0));
        pre(OPC_B);
        push(0, 1, 1, EXEC, o(0,0,0,1,1,0,0,0,0,0));
        run("branch");

        pre(OPC_J);
        push(0, 1, 0, EXEC, o(0,0,0,1,1,0,0,0,0,0));
        push(0, 1, 0, WB,   o(0,0,0,0,0,0,0,1,2,0));
        pre(OPC_IJALR);
        push(0, 1, 0, EXEC, o(0,0,0,1,2,0,0,0,0,0));
        push(0, 1, 0, WB,   o(0,0,0,0,0,0,0,1,2,0));
        run("jal_jalr");

        pre(OPC_U);
        push(0, 1, 0, EXEC, o(0,0,0,0,0,2,1,0,0,0));
        push(0, 1, 0, WB,   o(0,0,0,0,0,0,0,1,0,0));
        pre(OPC_AUIPC);
        push(0, 1, 0, EXEC, o(0,0,0,0,0,1,1,0,0,0));
        push(0, 1, 0, WB,   o(0,0,0,0,0,0,0,1,0,0));
        pre(OPC_R);
        push(0, 1, 0, EXEC, Z);
        push(0, 1, 0, WB,   o(0,0,0,0,0,0,0,1,0,0));
        run("lui_auipc_r");

        pre(OPC_S);
        push(0, 1, 0, EXEC, o(0,0,0,0,0,0,1,0,0,0));
        push(0, 0, 0, MEM,  o(0,1,0,0,0,0,0,0,0,0));
        push(0, 1, 0, MEM,  o(0,1,0,0,0,0,0,0,0,0));
        run("store_wait1");

        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,0));
        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,0));
        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,0));
        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,1));
        push(0, 0, 0, FETCH, Z);
        pre(OPC_I);
        push(0, 1, 0, EXEC, o(0,0,0,0,0,0,1,0,0,0));
        push(0, 1, 0, WB,   o(0,0,0,0,0,0,0,1,0,0));
        run("fetch_timeout");

        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,0));
        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,0));
        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,0));
        push(0, 1, 0, FETCH, o(1,0,1,1,0,0,0,0,0,0));
        push(0, 1, 0, DECODE, Z);
        push(0, 1, 0, EXEC, o(0,0,0,0,0,0,1,0,0,0));
        push(0, 1, 0, WB,   o(0,0,0,0,0,0,0,1,0,0));
        run("ready_at_limit");

        pre(OPC_S);
        push(0, 1, 0, EXEC, o(0,0,0,0,0,0,1,0,0,0));
        push(0, 0, 0, MEM,  o(0,1,0,0,0,0,0,0,0,0));
        push(0, 0, 0, MEM,  o(0,1,0,0,0,0,0,0,0,0));
        push(0, 0, 0, MEM,  o(0,1,0,0,0,0,0,0,0,0));
        push(0, 0, 0, MEM,  o(0,0,0,0,0,0,0,0,0,1));
        push(0, 0, 0, FETCH, Z);
        run("store_timeout");

        pre(OPC_S);
        push(0, 1, 0, EXEC, o(0,0,0,0,0,0,1,0,0,0));
        push(0, 0, 0, MEM,  o(0,1,0,0,0,0,0,0,0,0));
        push(1, 0, 0, MEM,  Z);
        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,0));
        run("rst_mid_store");

        pre(7'b1111111);
        push(0, 1, 1, EXEC, Z);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++)
            push(0, 1, 1, TRAP, Z);
        push(1, 1, 1, TRAP, Z);
        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,0));
`else
        push(0, 0, 0, FETCH, o(1,0,0,0,0,0,0,0,0,0));
`endif
        run("illegal");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
